fh_glyph_serializer: RTL and testbench

//  Consumer stage for fh_rom (256 x 96-bit glyph bitmaps, 1-cycle read latency).

---
 rtl/fh_glyph_serializer.sv | 155 +++++++++++++++
 tb/tb_fh_glyph_serializer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fh_glyph_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fh_glyph_serializer
// Description : Fetches one 96-bit glyph bitmap from fh_rom and streams it out
//               one pixel per accepted beat with glyph-local x/y coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module fh_glyph_serializer #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 96,
   parameter int GLYPH_W     = 8,
   parameter int GLYPH_H     = 12,
   parameter int ROM_LATENCY = 1,
   parameter int MSB_FIRST   = 1
) (
   input  logic                          clk,
   input  logic                          tb_rst,
   input  logic                          start,
   input  logic [ADDR_WIDTH-1:0]         glyph_idx,
   output logic                          busy,
   output logic [ADDR_WIDTH-1:0]         rom_addr,
   input  logic [DATA_WIDTH-1:0]         rom_data,
   output logic                          pix_valid,
   input  logic                          pix_ready,
   output logic                          pix_bit,
   output logic [$clog2(GLYPH_W)-1:0]    pix_x,
   output logic [$clog2(GLYPH_H)-1:0]    pix_y,
   output logic                          pix_last
);

   localparam int XW = $clog2(GLYPH_W);
   localparam int YW = $clog2(GLYPH_H);
   localparam int CW = $clog2(ROM_LATENCY + 1);
   localparam logic [XW-1:0] C_XMAX = XW'(GLYPH_W - 1);
   localparam logic [YW-1:0] C_YMAX = YW'(GLYPH_H - 1);
   localparam logic [CW-1:0] C_WAIT = CW'(ROM_LATENCY);

   // Reject geometries where the ROM word does not map exactly onto the glyph.
   generate
      if (DATA_WIDTH != GLYPH_W * GLYPH_H) begin : g_bad_geometry
         $error("fh_glyph_serializer: DATA_WIDTH must equal GLYPH_W*GLYPH_H");
      end
      if (ROM_LATENCY < 1 || ROM_LATENCY > 2) begin : g_bad_latency
         $error("fh_glyph_serializer: ROM_LATENCY must be 1 or 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
   logic [CW-1:0]           wcnt_q, wcnt_d;
   logic                    valid_q, valid_d;
   logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
   logic [XW-1:0]           x_q, x_d;
   logic [YW-1:0]           y_q, y_d;
   logic                    last_w;

   assign last_w = valid_q && (x_q == C_XMAX) && (y_q == C_YMAX);

   // Next-state logic: fetch, wait for ROM data, then shift out under handshake.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      rom_addr_d = rom_addr_q;
      wcnt_d     = wcnt_q;
      valid_d    = valid_q;
      shreg_d    = shreg_q;
      x_d        = x_q;
      y_d        = y_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rom_addr_d = glyph_idx;
               busy_d     = 1'b1;
               wcnt_d     = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // rom_data is valid once ROM_LATENCY clocks have passed since the address settled.
            if (wcnt_q == C_WAIT) begin
               shreg_d = rom_data;
               valid_d = 1'b1;
               x_d     = '0;
               y_d     = '0;
               state_d = ST_SHIFT;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (valid_q && pix_ready) begin
               if (MSB_FIRST != 0) begin
                  shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
               end else begin
                  shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
               end
               if (x_q == C_XMAX) begin
                  x_d = '0;
                  y_d = (y_q == C_YMAX) ? '0 : y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
               if (last_w) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset aborts any glyph in flight.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         rom_addr_q <= '0;
         wcnt_q     <= '0;
         valid_q    <= 1'b0;
         shreg_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         rom_addr_q <= rom_addr_d;
         wcnt_q     <= wcnt_d;
         valid_q    <= valid_d;
         shreg_q    <= shreg_d;
         x_q        <= x_d;
         y_q        <= y_d;
      end
   end

   assign busy      = busy_q;
   assign rom_addr  = rom_addr_q;
   assign pix_valid = valid_q;
   assign pix_bit   = (MSB_FIRST != 0) ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
   assign pix_x     = x_q;
   assign pix_y     = y_q;
   assign pix_last  = last_w;

endmodule
`default_nettype wire

// File: tb/tb_fh_glyph_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fh_glyph_serializer
// Description : Directed bench for fh_glyph_serializer, ROM latency 1 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fh_glyph_serializer;

   logic        clk = 1'b0;
   logic        tb_rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  glyph_idx = 8'h00;
   logic        pix_ready = 1'b0;
   logic        sel = 1'b0;

   logic        busy1, valid1, bit1, last1, busy2, valid2, bit2, last2;
   logic [7:0]  addr1, addr2;
   logic [2:0]  x1, x2;
   logic [3:0]  y1, y2;
   logic [95:0] rom_q1, rom_a2, rom_q2;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   // ROM contents: two special words, everything else is the index repeated.
   function automatic logic [95:0] rom_word(input logic [7:0] a);
      if (a == 8'h05)      return {1'b1, 94'b0, 1'b1};
      else if (a == 8'hFF) return {96{1'b1}};
      else                 return {12{a}};
   endfunction

   // ROM models: one register stage (latency 1) and two stages (latency 2).
   always @(posedge clk) begin
      rom_q1 <= rom_word(addr1);
      rom_a2 <= rom_word(addr2);
      rom_q2 <= rom_a2;
   end

   fh_glyph_serializer #(.ROM_LATENCY(1)) dut1 (
      .clk(clk), .tb_rst(tb_rst), .start(start & ~sel), .glyph_idx(glyph_idx),
      .busy(busy1), .rom_addr(addr1), .rom_data(rom_q1),
      .pix_valid(valid1), .pix_ready(pix_ready), .pix_bit(bit1),
      .pix_x(x1), .pix_y(y1), .pix_last(last1));

   fh_glyph_serializer #(.ROM_LATENCY(2)) dut2 (
      .clk(clk), .tb_rst(tb_rst), .start(start & sel), .glyph_idx(glyph_idx),
      .busy(busy2), .rom_addr(addr2), .rom_data(rom_q2),
      .pix_valid(valid2), .pix_ready(pix_ready), .pix_bit(bit2),
      .pix_x(x2), .pix_y(y2), .pix_last(last2));

   wire       busy  = sel ? busy2  : busy1;
   wire       valid = sel ? valid2 : valid1;
   wire       pbit  = sel ? bit2   : bit1;
   wire       last  = sel ? last2  : last1;
   wire [7:0] addr  = sel ? addr2  : addr1;
   wire [2:0] px    = sel ? x2     : x1;
   wire [3:0] py    = sel ? y2     : y1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Start one glyph and check every beat; stops early once abort_at beats are accepted.
   task automatic run_glyph(input logic [7:0] idx, input logic [3:0] pat,
                            input logic [95:0] word, input bit mid, input int abort_at);
      int k;
      int c;
      int lat;
      lat = sel ? 2 : 1;
      @(negedge clk);
      start = 1'b1; glyph_idx = idx; pix_ready = 1'b0;
      @(posedge clk); #1;
      check("accept", {busy, addr, valid}, {1'b1, idx, 1'b0});
      start = 1'b0; glyph_idx = 8'h00;
      for (int i = 0; i < lat; i++) begin
         @(posedge clk); #1;
         check("wait_valid", valid, 1'b0);
      end
      @(posedge clk); #1;
      check("first_valid", {valid, px, py}, {1'b1, 3'd0, 4'd0});
      k = 0; c = 0;
      while (k < 96 && k != abort_at && c < 500) begin
         @(negedge clk);
         pix_ready = pat[c % 4];
         start = 1'b0;
         if (mid && k == 30) begin start = 1'b1; glyph_idx = 8'h33; end
         if (mid && k == 95 && pix_ready) begin start = 1'b1; glyph_idx = 8'h44; end
         check("beat", {valid, pbit, px, py, last},
               {1'b1, word[95-k], 3'(k % 8), 4'(k / 8), (k == 95)});
         if (pix_ready) k++;
         c++;
         @(posedge clk);
      end
      start = 1'b0;
      if (c >= 500) begin
         failed++; tests++;
         $display("FAIL timeout: got %0d beats expected %0d", k, 96);
      end else if (k == 96) begin
         #1;
         check("done", {busy, valid, last}, 3'b000);
         check("addr_held", addr, idx);
         pix_ready = 1'b1;
         @(posedge clk); #1;
         check("stay_idle", {busy, valid}, 2'b00);
      end
   endtask

   // Abort a glyph with reset at beat 40, then render a full glyph.
   task automatic reset_case();
      run_glyph(8'h07, 4'b1111, {12{8'h07}}, 1'b0, 40);
      @(negedge clk);
      tb_rst = 1'b1;
      #1;
      check("rst_abort", {busy, addr, valid, pbit, px, py, last}, 18'd0);
      @(negedge clk);
      tb_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_quiet", {busy, valid}, 2'b00);
      run_glyph(8'h02, 4'b1111, 96'h020202020202020202020202, 1'b0, 96);
   endtask

   typedef struct {
      logic [7:0]  idx;
      logic [3:0]  pat;
      logic [95:0] word;
      bit          mid;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{8'h05, 4'b1111, 96'h800000000000000000000001, 1'b0};
      vecs[1] = '{8'hFF, 4'b1111, 96'hFFFFFFFFFFFFFFFFFFFFFFFF, 1'b0};
      vecs[2] = '{8'h10, 4'b1001, 96'h101010101010101010101010, 1'b1};
      vecs[3] = '{8'h3C, 4'b0110, 96'h3C3C3C3C3C3C3C3C3C3C3C3C, 1'b0};

      #200;
      check("reset1", {busy1, addr1, valid1, bit1, x1, y1, last1}, 18'd0);
      check("reset2", {busy2, addr2, valid2, bit2, x2, y2, last2}, 18'd0);
      @(negedge clk);
      tb_rst = 1'b0;

      sel = 1'b0;
      for (int v = 0; v < 4; v++) begin
         run_glyph(vecs[v].idx, vecs[v].pat, vecs[v].word, vecs[v].mid, 96);
      end
      reset_case();

      sel = 1'b1;
      run_glyph(8'h05, 4'b1001, 96'h800000000000000000000001, 1'b1, 96);
      reset_case();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
